multi_delay_timer: RTL and testbench

MULTI_DELAY_TIMER -- requirements
Module: multi_delay_timer

---
 rtl/delay_pkg.sv | 22 ++
 rtl/multi_delay_timer_if.sv | 33 +++
 rtl/delay_chan.sv | 121 ++++++++++++
 rtl/multi_delay_timer.sv | 48 ++++
 tb/tb_multi_delay_timer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_pkg.sv
// Shared types and defaults for the multi-channel delay timer.
package delay_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_e;

   typedef enum logic {
      PERIODIC = 1'b0,
      ONESHOT  = 1'b1
   } mode_e;

   localparam int unsigned DEF_PERIOD_DEFAULT = 750;
   localparam int unsigned NCH_MAX            = 16;

   // Channel-select width: never narrower than one bit, even for a single channel.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/multi_delay_timer_if.sv
// Configuration, per-channel control and status bundle for multi_delay_timer.
interface multi_delay_timer_if
   import delay_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int CBITS = 10,
   parameter int CHB   = sel_width(NCH)
);

   logic             cfg_valid;
   logic [CHB-1:0]   cfg_ch;
   logic [CBITS-1:0] cfg_period;
   logic             cfg_mode;
   logic [NCH-1:0]   start;
   logic [NCH-1:0]   stop;
   logic [NCH-1:0]   clr_err;
   logic [NCH-1:0]   sig;
   logic [NCH-1:0]   busy;
   logic [NCH-1:0]   err;

   modport master (
      output cfg_valid, cfg_ch, cfg_period, cfg_mode,
      output start, stop, clr_err,
      input  sig, busy, err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_period, cfg_mode,
      input  start, stop, clr_err,
      output sig, busy, err
   );

endinterface

// File: rtl/delay_chan.sv
// One timer channel: IDLE/COUNT FSM, counter, period/mode registers and sticky error.
module delay_chan
   import delay_pkg::*;
#(
   parameter int CBITS      = 10,
   parameter int DEF_PERIOD = DEF_PERIOD_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_wr,
   input  logic [CBITS-1:0] cfg_period,
   input  logic             cfg_mode,
   input  logic             start,
   input  logic             stop,
   input  logic             clr_err,
   output logic             sig,
   output logic             busy,
   output logic             err
);

   localparam logic [CBITS-1:0] DEF_P = CBITS'(DEF_PERIOD);

   state_e           state_q, state_d;
   logic [CBITS-1:0] cnt_q, cnt_d;
   logic [CBITS-1:0] per_q, per_d;
   mode_e            mode_q, mode_d;
   logic [CBITS-1:0] run_per_q, run_per_d;
   mode_e            run_mode_q, run_mode_d;
   logic             sig_q, sig_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             err_set;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      per_d      = per_q;
      mode_d     = mode_q;
      run_per_d  = run_per_q;
      run_mode_d = run_mode_q;
      sig_d      = 1'b0;
      err_set    = 1'b0;

      if (cfg_wr) begin
         if (state_q == IDLE) begin
            per_d  = cfg_period;
            mode_d = mode_e'(cfg_mode);
         end else begin
            err_set = 1'b1;
         end
      end
      // A new error in the same cycle as a clear keeps the flag set.
      err_d = err_set | (err_q & ~clr_err);

      // The running count compares against a copy taken at start, so a config
      // write landing in the start cycle only affects the next start.
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start && !stop) begin
               state_d    = COUNT;
               run_per_d  = per_q;
               run_mode_d = mode_q;
            end
         end
         COUNT: begin
            if (stop) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (start) begin
               cnt_d      = '0;
               run_per_d  = per_q;
               run_mode_d = mode_q;
            end else if (cnt_q == run_per_q) begin
               sig_d = 1'b1;
               cnt_d = '0;
               if (run_mode_q == ONESHOT) begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d == COUNT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         per_q      <= DEF_P;
         mode_q     <= PERIODIC;
         run_per_q  <= DEF_P;
         run_mode_q <= PERIODIC;
         sig_q      <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         per_q      <= per_d;
         mode_q     <= mode_d;
         run_per_q  <= run_per_d;
         run_mode_q <= run_mode_d;
         sig_q      <= sig_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign sig  = sig_q;
   assign busy = busy_q;
   assign err  = err_q;

endmodule

// File: rtl/multi_delay_timer.sv
// NCH independent delay timers; the top level only decodes the config target.
module multi_delay_timer
   import delay_pkg::*;
#(
   parameter int NCH        = 4,
   parameter int CBITS      = 10,
   parameter int DEF_PERIOD = DEF_PERIOD_DEFAULT,
   parameter int CHB        = sel_width(NCH)
) (
   input  logic                clk,
   input  logic                rst,
   multi_delay_timer_if.slave  bus
);

   logic [NCH-1:0] cfg_wr;

   // Selects above NCH-1 match no channel, so such writes vanish silently.
   always_comb begin
      cfg_wr = '0;
      if (bus.cfg_valid) begin
         for (int i = 0; i < NCH; i++) begin
            if (bus.cfg_ch == CHB'(i)) begin
               cfg_wr[i] = 1'b1;
            end
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      delay_chan #(
         .CBITS      (CBITS),
         .DEF_PERIOD (DEF_PERIOD)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .cfg_wr     (cfg_wr[i]),
         .cfg_period (bus.cfg_period),
         .cfg_mode   (bus.cfg_mode),
         .start      (bus.start[i]),
         .stop       (bus.stop[i]),
         .clr_err    (bus.clr_err[i]),
         .sig        (bus.sig[i]),
         .busy       (bus.busy[i]),
         .err        (bus.err[i])
      );
   end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Directed bench for multi_delay_timer with an expectation queue drained each cycle.
module tb_multi_delay_timer;

   localparam int NCH   = 4;
   localparam int CBITS = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   multi_delay_timer_if #(.NCH(NCH), .CBITS(CBITS), .CHB(2)) bus ();

   multi_delay_timer #(
      .NCH        (NCH),
      .CBITS      (CBITS),
      .DEF_PERIOD (750),
      .CHB        (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef enum int {K_SIG, K_BUSY, K_ERR} kind_e;
   typedef struct {
      string tag;
      kind_e kind;
      int    ch;
      logic  val;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   function automatic logic obs_of(kind_e k, int ch);
      case (k)
         K_SIG:   return bus.sig[ch];
         K_BUSY:  return bus.busy[ch];
         default: return bus.err[ch];
      endcase
   endfunction

   task automatic push(string tag, kind_e k, int ch, logic v);
      exp_t e;
      e.tag  = tag;
      e.kind = k;
      e.ch   = ch;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic push_sb(string tag, int ch, logic s, logic b);
      push(tag, K_SIG, ch, s);
      push(tag, K_BUSY, ch, b);
   endtask

   task automatic check();
      exp_t e;
      logic o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs_of(e.kind, e.ch);
         tests++;
         assert (o === e.val) else begin
            fails++;
            $error("FAIL %s ch%0d %s observed=%b expected=%b", e.tag, e.ch, e.kind.name(), o, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cfg_write(int ch, int p, logic m);
      bus.cfg_valid  = 1'b1;
      bus.cfg_ch     = 2'(ch);
      bus.cfg_period = 10'(p);
      bus.cfg_mode   = m;
      tick();
      bus.cfg_valid  = 1'b0;
   endtask

   task automatic do_start(logic [NCH-1:0] m);
      bus.start = m;
      tick();
      bus.start = '0;
   endtask

   task automatic do_stop(logic [NCH-1:0] m);
      bus.stop = m;
      tick();
      bus.stop = '0;
   endtask

   initial begin
      bus.cfg_valid  = 1'b0;
      bus.cfg_ch     = '0;
      bus.cfg_period = '0;
      bus.cfg_mode   = 1'b0;
      bus.start      = '0;
      bus.stop       = '0;
      bus.clr_err    = '0;

      tick();
      tick();
      for (int c = 0; c < NCH; c++) begin
         push_sb("reset", c, 1'b0, 1'b0);
         push("reset", K_ERR, c, 1'b0);
      end
      check();
      rst = 1'b0;

      // Periodic P=3 on ch0: pulse every 4 cycles after start
      cfg_write(0, 3, 1'b0);
      do_start(4'b0001);
      push_sb("p3_start", 0, 1'b0, 1'b1);
      check();
      for (int n = 1; n <= 12; n++) begin
         tick();
         push_sb("p3_run", 0, (n % 4 == 0), 1'b1);
         check();
      end
      do_stop(4'b0001);
      push_sb("p3_stop", 0, 1'b0, 1'b0);
      check();

      // One-shot P=5 on ch1: single pulse after 6 cycles, busy drops with it
      cfg_write(1, 5, 1'b1);
      do_start(4'b0010);
      push_sb("os_start", 1, 1'b0, 1'b1);
      check();
      for (int n = 1; n <= 12; n++) begin
         tick();
         push_sb("os_run", 1, (n == 6), (n < 6));
         check();
      end

      // Config write while counting: error, period kept, clear and set-wins
      do_start(4'b0100);
      push_sb("err_start", 2, 1'b0, 1'b1);
      check();
      cfg_write(2, 2, 1'b0);
      push("err_set", K_ERR, 2, 1'b1);
      push("err_set", K_BUSY, 2, 1'b1);
      check();
      do_stop(4'b0100);
      do_start(4'b0100);
      for (int n = 1; n <= 6; n++) begin
         tick();
         push_sb("p_kept", 2, 1'b0, 1'b1);
         push("err_hold", K_ERR, 2, 1'b1);
         check();
      end
      bus.clr_err = 4'b0100;
      tick();
      bus.clr_err = '0;
      push("err_clr", K_ERR, 2, 1'b0);
      check();
      bus.clr_err = 4'b0100;
      cfg_write(2, 2, 1'b0);
      bus.clr_err = '0;
      push("err_setwins", K_ERR, 2, 1'b1);
      check();
      bus.clr_err = 4'b0100;
      tick();
      bus.clr_err = '0;
      push("err_clr2", K_ERR, 2, 1'b0);
      check();
      do_stop(4'b0100);

      // ch0 at cnt=2: start+stop together -> idle, no pulse
      do_start(4'b0001);
      tick();
      tick();
      bus.start = 4'b0001;
      bus.stop  = 4'b0001;
      tick();
      bus.start = '0;
      bus.stop  = '0;
      push_sb("ss_idle", 0, 1'b0, 1'b0);
      check();
      for (int n = 1; n <= 6; n++) begin
         tick();
         push_sb("ss_quiet", 0, 1'b0, 1'b0);
         check();
      end

      // Restart exactly at cnt==P suppresses the pulse and recounts from 0
      do_start(4'b0001);
      for (int n = 1; n <= 3; n++) begin
         tick();
         push_sb("rs_pre", 0, 1'b0, 1'b1);
         check();
      end
      do_start(4'b0001);
      push_sb("rs_edge", 0, 1'b0, 1'b1);
      check();
      for (int n = 1; n <= 8; n++) begin
         tick();
         push_sb("rs_run", 0, (n % 4 == 0), 1'b1);
         check();
      end
      do_stop(4'b0001);

      // P=0: sig every cycle; stop at cnt==P gives no pulse
      cfg_write(3, 0, 1'b0);
      do_start(4'b1000);
      push_sb("p0_start", 3, 1'b0, 1'b1);
      check();
      for (int n = 1; n <= 5; n++) begin
         tick();
         push_sb("p0_run", 3, 1'b1, 1'b1);
         check();
      end
      do_stop(4'b1000);
      push_sb("p0_stop", 3, 1'b0, 1'b0);
      check();

      // P=1023: pulse every 1024 cycles, no wrap
      cfg_write(3, 1023, 1'b0);
      do_start(4'b1000);
      push_sb("pmax_start", 3, 1'b0, 1'b1);
      check();
      for (int n = 1; n <= 2050; n++) begin
         tick();
         push("pmax", K_SIG, 3, (n % 1024 == 0));
         if (n % 256 == 0) push("pmax", K_BUSY, 3, 1'b1);
         check();
      end
      do_stop(4'b1000);

      // Reset with all channels counting; ch1 sits at cnt==P on the reset edge
      cfg_write(1, 5, 1'b0);
      do_start(4'b1111);
      repeat (4) tick();
      cfg_write(0, 7, 1'b0);
      push("pre_rst_err", K_ERR, 0, 1'b1);
      for (int c = 0; c < NCH; c++) push("pre_rst_busy", K_BUSY, c, 1'b1);
      check();
      rst = 1'b1;
      tick();
      for (int c = 0; c < NCH; c++) begin
         push_sb("rst_mid", c, 1'b0, 1'b0);
         push("rst_mid", K_ERR, c, 1'b0);
      end
      check();
      rst = 1'b0;

      // Period back at 750 everywhere: first pulse 751 cycles after start
      do_start(4'b1111);
      for (int c = 0; c < NCH; c++) push_sb("def_start", c, 1'b0, 1'b1);
      check();
      for (int n = 1; n <= 760; n++) begin
         tick();
         for (int c = 0; c < NCH; c++) push_sb("def_p", c, (n == 751), 1'b1);
         check();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
